// File: rtl/bcd_display_unit.sv
// Binary-to-7-segment display unit: sequential double-dabble conversion with valid/ready
// handshake, leading-zero blanking, sign digit and sticky overflow indication.
module bcd_display_unit #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int SIGNED_MODE = 0,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [WIDTH-1:0]      binary,
  output logic                  outValid,
  output logic [7*DIGITS-1:0]   segments,
  output logic [6:0]            signSeg,
  output logic                  negative,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    mag_q, mag_d;
  logic [BW-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]       cnt_q;
  logic                ovf_q;
  logic                sign_q;
  logic [7*DIGITS-1:0] seg_q, seg_dec;
  logic [6:0]          sign_seg_q;
  logic                negative_q, overflow_q, out_valid_q;
  logic [WIDTH-1:0]    in_mag;
  logic                in_neg;
  logic [3:0]          nib;
  logic                nz;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Negative inputs are converted as their magnitude; 8'h80 yields 128 held unsigned.
  assign in_neg = (SIGNED_MODE != 0) && binary[WIDTH-1];
  assign in_mag = in_neg ? (~binary + WIDTH'(1)) : binary;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
    mag_d = {mag_q[WIDTH-2:0], 1'b0};
  end

  // Scan from the top digit down; a digit is visible once any digit at or above it is non-zero.
  always_comb begin
    seg_dec = '0;
    nz      = 1'b0;
    nib     = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = bcd_q[4*i +: 4];
      nz  = nz | (nib != 4'd0) | (i == 0);
      if (ovf_q)                    seg_dec[7*i +: 7] = SEG_DASH;
      else if (BLANK_LZ != 0 && !nz) seg_dec[7*i +: 7] = SEG_BLANK;
      else                           seg_dec[7*i +: 7] = seg7(nib);
    end
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sign_q      <= 1'b0;
      seg_q       <= {DIGITS{SEG_BLANK}};
      sign_seg_q  <= SEG_BLANK;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the pre-edge values.
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) begin
            seg_q       <= seg_dec;
            sign_seg_q  <= sign_q ? SEG_DASH : SEG_BLANK;
            negative_q  <= sign_q;
            overflow_q  <= ovf_q;
            out_valid_q <= 1'b1;
          end
          if (inValid) begin
            mag_q   <= in_mag;
            sign_q  <= in_neg;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          mag_q <= mag_d;
          bcd_q <= bcd_d;
          ovf_q <= ovf_q | bcd_adj[BW-1];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inReady  = (state_q != SHIFT);
  assign outValid = out_valid_q;
  assign segments = seg_q;
  assign signSeg  = sign_seg_q;
  assign negative = negative_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_display_unit.sv
// Directed bench for bcd_display_unit: three instances cover unsigned/3 digits,
// unsigned/2 digits (overflow) and signed/3 digits, sharing clock and reset.
module tb_bcd_display_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        in_valid [3];
  logic [7:0]  in_bin   [3];
  logic [2:0]  ir, ov, neg, ovf;
  logic [20:0] seg_a, seg_s;
  logic [13:0] seg_b;
  logic [6:0]  ss_a, ss_b, ss_s;

  int compared   = 0;
  int mismatched = 0;

  bcd_display_unit #(.WIDTH(8), .DIGITS(3), .SIGNED_MODE(0), .BLANK_LZ(1)) u_dut_a (
    .clock(clock), .reset(reset), .inValid(in_valid[0]), .inReady(ir[0]), .binary(in_bin[0]),
    .outValid(ov[0]), .segments(seg_a), .signSeg(ss_a), .negative(neg[0]), .overflow(ovf[0]));

  bcd_display_unit #(.WIDTH(8), .DIGITS(2), .SIGNED_MODE(0), .BLANK_LZ(1)) u_dut_b (
    .clock(clock), .reset(reset), .inValid(in_valid[1]), .inReady(ir[1]), .binary(in_bin[1]),
    .outValid(ov[1]), .segments(seg_b), .signSeg(ss_b), .negative(neg[1]), .overflow(ovf[1]));

  bcd_display_unit #(.WIDTH(8), .DIGITS(3), .SIGNED_MODE(1), .BLANK_LZ(1)) u_dut_s (
    .clock(clock), .reset(reset), .inValid(in_valid[2]), .inReady(ir[2]), .binary(in_bin[2]),
    .outValid(ov[2]), .segments(seg_s), .signSeg(ss_s), .negative(neg[2]), .overflow(ovf[2]));

  function automatic logic [20:0] seg_of(input int d);
    case (d)
      0:       return seg_a;
      1:       return {7'h00, seg_b};
      default: return seg_s;
    endcase
  endfunction

  function automatic logic [6:0] ss_of(input int d);
    case (d)
      0:       return ss_a;
      1:       return ss_b;
      default: return ss_s;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake one value, then follow the request: ready must stay low through the
  // 8 SHIFT cycles and outValid must appear exactly in the cycle after edge k+9.
  task automatic convert(input int d, input logic [7:0] v, input string tag);
    int lat;
    int ir_bad;
    lat    = -1;
    ir_bad = 0;
    @(negedge clock);
    check({tag, " ready"}, 32'(ir[d]), 32'd1);
    in_valid[d] = 1'b1;
    in_bin[d]   = v;
    @(posedge clock);
    for (int n = 0; n < 20 && lat < 0; n++) begin
      @(negedge clock);
      if (n == 0) begin
        in_valid[d] = 1'b0;
        in_bin[d]   = ~v;
      end
      if (n < 8 && ir[d]) ir_bad++;
      if (ov[d]) lat = n;
    end
    check({tag, " latency"}, 32'(lat), 32'd9);
    check({tag, " busy"}, 32'(ir_bad), 32'd0);
    @(negedge clock);
    check({tag, " pulse"}, 32'(ov[d]), 32'd0);
  endtask

  initial begin
    int stray;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      in_bin[i]   = 8'h00;
    end
    repeat (3) @(negedge clock);
    check("rst seg", 32'(seg_a), 32'h1FFFFF);
    check("rst sign", 32'(ss_a), 32'h7F);
    check("rst valid", 32'(ov), 32'd0);
    check("rst flags", 32'({neg, ovf}), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rst ready", 32'(ir), 32'h7);

    convert(0, 8'd237, "u237");
    check("u237 seg", 32'(seg_a), 32'({7'h24, 7'h30, 7'h78}));
    check("u237 ovf", 32'(ovf[0]), 32'd0);
    check("u237 sign", 32'({neg[0], ss_a}), 32'h7F);

    convert(0, 8'd5, "u5");
    check("u5 seg", 32'(seg_a), 32'({7'h7F, 7'h7F, 7'h12}));
    convert(0, 8'd0, "u0");
    check("u0 seg", 32'(seg_a), 32'({7'h7F, 7'h7F, 7'h40}));

    convert(1, 8'd200, "d200");
    check("d200 ovf", 32'(ovf[1]), 32'd1);
    check("d200 seg", 32'(seg_b), 32'({7'h3F, 7'h3F}));
    check("d200 sign", 32'(ss_b), 32'h7F);
    convert(1, 8'd99, "d99");
    check("d99 ovf", 32'(ovf[1]), 32'd0);
    check("d99 seg", 32'(seg_b), 32'({7'h10, 7'h10}));

    convert(2, 8'hF6, "sF6");
    check("sF6 neg", 32'(neg[2]), 32'd1);
    check("sF6 sign", 32'(ss_s), 32'h3F);
    check("sF6 seg", 32'(seg_s), 32'({7'h7F, 7'h79, 7'h40}));
    check("sF6 ovf", 32'(ovf[2]), 32'd0);
    convert(2, 8'h80, "s80");
    check("s80 neg", 32'(neg[2]), 32'd1);
    check("s80 seg", 32'(seg_s), 32'({7'h79, 7'h24, 7'h00}));
    convert(2, 8'd42, "s42");
    check("s42 neg", 32'({neg[2], ss_s}), 32'h7F);
    check("s42 seg", 32'(seg_s), 32'({7'h7F, 7'h19, 7'h24}));

    // Back-to-back: binary = 13*c+11 changes every cycle; handshakes fall on c = 0, 9, 18
    // (values 11, 128, 245) and their results appear at c = 10, 19, 28.
    stray = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (c == 10) begin
        check("b2b v0", 32'(ov[0]), 32'd1);
        check("b2b s0", 32'(seg_a), 32'({7'h7F, 7'h79, 7'h79}));
      end else if (c == 19) begin
        check("b2b v1", 32'(ov[0]), 32'd1);
        check("b2b s1", 32'(seg_a), 32'({7'h79, 7'h24, 7'h00}));
      end else if (c == 28) begin
        check("b2b v2", 32'(ov[0]), 32'd1);
        check("b2b s2", 32'(seg_a), 32'({7'h24, 7'h19, 7'h12}));
      end else if (ov[0]) begin
        stray++;
      end
      in_valid[0] = (c < 27);
      in_bin[0]   = 8'(c * 13 + 11);
    end
    check("b2b stray", 32'(stray), 32'd0);

    // Abort: reset asserted during the 4th SHIFT cycle of a 237 request.
    @(negedge clock);
    in_valid[0] = 1'b1;
    in_bin[0]   = 8'd237;
    @(posedge clock);
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      if (n == 0) in_valid[0] = 1'b0;
      if (n == 3) reset = 1'b0;
    end
    @(negedge clock);
    check("abort ready", 32'(ir[0]), 32'd1);
    check("abort seg", 32'(seg_a), 32'h1FFFFF);
    check("abort sign", 32'(ss_of(0)), 32'h7F);
    check("abort seg s", 32'(seg_of(2)), 32'h1FFFFF);
    reset = 1'b1;
    stray = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clock);
      if (ov[0]) stray++;
    end
    check("abort nopulse", 32'(stray), 32'd0);
    convert(0, 8'd42, "r42");
    check("r42 seg", 32'(seg_a), 32'({7'h7F, 7'h19, 7'h24}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
